pcie_read_mod: RTL and testbench

//  Host-to-FPGA mailbox reader for HySim PCIe control; inbound counterpart of the core write path.

---
 rtl/pcie_read_mod_pkg.sv | 20 ++
 rtl/pcie_read_mod.sv | 155 +++++++++++++++
 tb/tb_pcie_read_mod.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_read_mod_pkg.sv
// Shared PCIe mailbox definitions: read-path FSM states, mailbox word offsets, toggle bit.
package libpcie;

  typedef enum logic [2:0] {
    IDLE,
    POLL_I,
    POLL_W,
    RD_I,
    RD_W,
    PRESENT
  } pcie_rd_state_type;

  localparam logic [1:0] W0 = 2'd0;
  localparam logic [1:0] W1 = 2'd1;
  localparam logic [1:0] W2 = 2'd2;
  localparam logic [1:0] W3 = 2'd3;

  localparam int TOG_BIT = 31;

endpackage

// File: rtl/pcie_read_mod.sv
// Host-to-FPGA mailbox reader: polls word 3 for a toggle flip, then reads words 0..2
// and presents the 128-bit message over a valid/accept handshake.
module pcie_read_mod
  import libpcie::*;
#(
  parameter logic [10:0] BASE_ADDR = 11'h004,
  parameter int          RD_LAT    = 1,
  parameter int          POLL_GAP  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         RAM_busy,
  input  logic [31:0]  RAM_rdata,
  output logic [10:0]  RAM_addr,
  output logic         RAM_rd_en,
  output logic [127:0] FPGA_data,
  output logic         valid,
  input  logic         accept
);

  localparam logic [2:0]  LAT = 3'(RD_LAT);
  localparam logic [15:0] GAP = 16'(POLL_GAP);

  pcie_rd_state_type r_state, w_state_nxt;
  logic [15:0]  r_gap, w_gap_nxt;
  logic [2:0]   r_lat, w_lat_nxt;
  logic [1:0]   r_idx, w_idx_nxt;
  logic [31:0]  r_w0, r_w1, r_w3;
  logic         r_exp_tog, w_tog_nxt;
  logic [10:0]  r_addr, w_addr_nxt;
  logic         r_rd_en, w_rd_en_nxt;
  logic [127:0] r_data;
  logic         r_valid, w_valid_nxt;
  logic         w_req, w_req_poll;
  logic [1:0]   w_req_off;
  logic         w_lat_done, w_tog_hit, w_load;

  assign w_lat_done = (r_lat == LAT);
  assign w_tog_hit  = (RAM_rdata[TOG_BIT] == r_exp_tog);
  assign w_load     = (r_state == RD_W) && w_lat_done && (r_idx == W2);

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_lat_nxt   = r_lat;
    w_idx_nxt   = r_idx;
    w_tog_nxt   = r_exp_tog;
    w_addr_nxt  = r_addr;
    w_rd_en_nxt = 1'b0;
    w_valid_nxt = r_valid;
    w_req       = 1'b0;
    w_req_poll  = 1'b0;
    w_req_off   = W0;
    case (r_state)
      IDLE: begin
        // Issuing on the last gap count keeps exactly POLL_GAP idle cycles between polls.
        if (r_gap != 16'd0) w_gap_nxt = r_gap - 16'd1;
        if (r_gap <= 16'd1 && enable) begin
          w_req      = 1'b1;
          w_req_poll = 1'b1;
          w_req_off  = W3;
        end
      end
      POLL_I: begin
        w_req      = 1'b1;
        w_req_poll = 1'b1;
        w_req_off  = W3;
      end
      POLL_W: begin
        if (!w_lat_done) w_lat_nxt = r_lat + 3'd1;
        else if (w_tog_hit) begin
          w_idx_nxt = W0;
          w_req     = 1'b1;
          w_req_off = W0;
        end else begin
          w_state_nxt = IDLE;
          w_gap_nxt   = GAP;
        end
      end
      RD_I: begin
        w_req     = 1'b1;
        w_req_off = r_idx;
      end
      RD_W: begin
        if (!w_lat_done) w_lat_nxt = r_lat + 3'd1;
        else if (r_idx != W2) begin
          w_idx_nxt = r_idx + 2'd1;
          w_req     = 1'b1;
          w_req_off = r_idx + 2'd1;
        end else begin
          w_state_nxt = PRESENT;
          w_valid_nxt = 1'b1;
        end
      end
      PRESENT: begin
        if (r_valid && accept) begin
          w_valid_nxt = 1'b0;
          w_tog_nxt   = ~r_exp_tog;
          w_state_nxt = IDLE;
          w_gap_nxt   = GAP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Read requests issue straight from the deciding cycle; busy parks the FSM in *_I.
    if (w_req) begin
      w_addr_nxt = BASE_ADDR + {9'd0, w_req_off};
      w_lat_nxt  = 3'd0;
      if (!RAM_busy) begin
        w_rd_en_nxt = 1'b1;
        w_state_nxt = w_req_poll ? POLL_W : RD_W;
      end else begin
        w_state_nxt = w_req_poll ? POLL_I : RD_I;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gap     <= '0;
      r_lat     <= '0;
      r_idx     <= W0;
      r_w0      <= '0;
      r_w1      <= '0;
      r_w3      <= '0;
      r_exp_tog <= 1'b1;
      r_addr    <= '0;
      r_rd_en   <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap     <= w_gap_nxt;
      r_lat     <= w_lat_nxt;
      r_idx     <= w_idx_nxt;
      r_exp_tog <= w_tog_nxt;
      r_addr    <= w_addr_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_valid   <= w_valid_nxt;
      if (r_state == POLL_W && w_lat_done) r_w3 <= RAM_rdata;
      if (r_state == RD_W && w_lat_done && r_idx == W0) r_w0 <= RAM_rdata;
      if (r_state == RD_W && w_lat_done && r_idx == W1) r_w1 <= RAM_rdata;
      // Word 2 goes straight into the message as it arrives.
      if (w_load) r_data <= {r_w3, RAM_rdata, r_w1, r_w0};
    end
  end

  assign RAM_addr  = r_addr;
  assign RAM_rd_en = r_rd_en;
  assign FPGA_data = r_data;
  assign valid     = r_valid;

endmodule

// File: tb/tb_pcie_read_mod.sv
// Directed bench for pcie_read_mod: RAM model with 1-cycle latency, read-strobe log, expected cycles by hand.
module tb_pcie_read_mod;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         RAM_busy = 1'b0;
  logic         accept = 1'b0;
  logic [31:0]  RAM_rdata = '0;
  logic [10:0]  RAM_addr;
  logic         RAM_rd_en;
  logic [127:0] FPGA_data;
  logic         valid;

  logic [31:0]  mem [0:2047];
  int           cyc = 0;
  int           n_tot = 0;
  int           n_bad = 0;
  int           v_cyc = -1;
  logic         v_prev = 1'b0;
  int           ev_cyc[$];
  logic [10:0]  ev_addr[$];
  int           k;
  int           a;

  localparam logic [127:0] MSG1 = 128'h80000044_33333333_22222222_11111111;

  pcie_read_mod dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .RAM_busy(RAM_busy),
    .RAM_rdata(RAM_rdata), .RAM_addr(RAM_addr), .RAM_rd_en(RAM_rd_en),
    .FPGA_data(FPGA_data), .valid(valid), .accept(accept)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (RAM_rd_en) RAM_rdata <= mem[RAM_addr];
  end

  // Log read strobes and valid rises against the cycle index.
  always @(posedge clk) begin
    #2;
    if (RAM_rd_en === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_addr.push_back(RAM_addr);
    end
    if (valid === 1'b1 && v_prev !== 1'b1) v_cyc = cyc;
    v_prev = valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_ev(input int i, input int ecyc, input logic [10:0] eaddr);
    if (i < ev_cyc.size()) begin
      chk($sformatf("ev%0d_cyc", i), 128'(ev_cyc[i]), 128'(ecyc));
      chk($sformatf("ev%0d_addr", i), 128'(ev_addr[i]), 128'(eaddr));
    end else begin
      chk($sformatf("ev%0d_missing", i), 128'(ev_cyc.size()), 128'(i + 1));
    end
  endtask

  task automatic put_msg(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    mem[4] = w0;
    mem[5] = w1;
    mem[6] = w2;
    mem[7] = w3;
  endtask

  task automatic do_rst();
    rst_n = 1'b0;
    enable = 1'b0;
    RAM_busy = 1'b0;
    accept = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int lim);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("valid_wait", 128'(valid), 128'(1));
  endtask

  task automatic clr_ev();
    ev_cyc.delete();
    ev_addr.delete();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;

    // Reset values, then 50 disabled cycles
    rst_n = 1'b0;
    ticks(2);
    chk("rst_addr", 128'(RAM_addr), 128'(0));
    chk("rst_rd_en", 128'(RAM_rd_en), 128'(0));
    chk("rst_data", FPGA_data, 128'(0));
    chk("rst_valid", 128'(valid), 128'(0));
    rst_n = 1'b1;
    ticks(50);
    chk("dis_no_rd", 128'(ev_cyc.size()), 128'(0));
    chk("dis_valid", 128'(valid), 128'(0));
    chk("dis_data", FPGA_data, 128'(0));

    // Basic message, RD_LAT=1, no busy
    put_msg(32'h11111111, 32'h22222222, 32'h33333333, 32'h80000044);
    clr_ev();
    k = cyc;
    enable = 1'b1;
    wait_valid(30);
    chk_ev(0, k + 1, 11'h007);
    chk_ev(1, k + 3, 11'h004);
    chk_ev(2, k + 5, 11'h005);
    chk_ev(3, k + 7, 11'h006);
    chk("msg1_vcyc", 128'(v_cyc), 128'(k + 9));
    chk("msg1_data", FPGA_data, MSG1);

    // Hold in PRESENT, accept, stale polls, then a toggle=0 message
    clr_ev();
    ticks(10);
    chk("hold_valid", 128'(valid), 128'(1));
    chk("hold_data", FPGA_data, MSG1);
    chk("hold_no_rd", 128'(ev_cyc.size()), 128'(0));
    a = cyc;
    accept = 1'b1;
    tick();
    chk("acc_valid_low", 128'(valid), 128'(0));
    accept = 1'b0;
    clr_ev();
    ticks(35);
    chk("stale_valid", 128'(valid), 128'(0));
    chk_ev(0, a + 9, 11'h007);
    chk_ev(1, a + 19, 11'h007);
    chk_ev(2, a + 29, 11'h007);
    put_msg(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'h00000055);
    wait_valid(40);
    chk("msg2_data", FPGA_data, 128'h00000055_C2C2C2C2_B1B1B1B1_A0A0A0A0);
    accept = 1'b1;
    tick();
    accept = 1'b0;

    // Stale toggle after reset: polls only, every 10 cycles
    do_rst();
    put_msg(32'h0, 32'h0, 32'h0, 32'h00000044);
    clr_ev();
    k = cyc;
    enable = 1'b1;
    ticks(45);
    chk("poll_valid", 128'(valid), 128'(0));
    for (int i = 0; i < 5; i++) chk_ev(i, k + 1 + 10 * i, 11'h007);
    chk("poll_count", 128'(ev_cyc.size()), 128'(5));

    // RAM_busy for 5 cycles delays the word-1 read by 5
    do_rst();
    put_msg(32'h11111111, 32'h22222222, 32'h33333333, 32'h80000044);
    clr_ev();
    k = cyc;
    enable = 1'b1;
    ticks(4);
    RAM_busy = 1'b1;
    ticks(3);
    chk("busy_addr_hold", 128'(RAM_addr), 128'(11'h005));
    chk("busy_no_rd", 128'(RAM_rd_en), 128'(0));
    ticks(2);
    RAM_busy = 1'b0;
    wait_valid(20);
    chk_ev(0, k + 1, 11'h007);
    chk_ev(1, k + 3, 11'h004);
    chk_ev(2, k + 10, 11'h005);
    chk_ev(3, k + 12, 11'h006);
    chk("busy_vcyc", 128'(v_cyc), 128'(k + 14));
    chk("busy_data", FPGA_data, MSG1);

    // Reset during word-1 wait discards the partial message
    do_rst();
    put_msg(32'h01010101, 32'h02020202, 32'h03030303, 32'hC0000077);
    clr_ev();
    k = cyc;
    enable = 1'b1;
    ticks(5);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_rd_en", 128'(RAM_rd_en), 128'(0));
    chk("mid_rst_valid", 128'(valid), 128'(0));
    chk("mid_rst_addr", 128'(RAM_addr), 128'(0));
    rst_n = 1'b1;
    mem[4] = 32'h0F0F0F0F;
    clr_ev();
    wait_valid(30);
    chk_ev(0, k + 7, 11'h007);
    chk_ev(1, k + 9, 11'h004);
    chk_ev(2, k + 11, 11'h005);
    chk_ev(3, k + 13, 11'h006);
    chk("reread_vcyc", 128'(v_cyc), 128'(k + 15));
    chk("reread_data", FPGA_data, 128'hC0000077_03030303_02020202_0F0F0F0F);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
